// File: rtl/fpsr_vga_pkg.sv
// Shared VGA definitions: colour constants, counter width, sync bundle and
// the overflow-safe box test used for on-screen squares.
package fpsr_vga_pkg;

  localparam int CW_DEF = 12;
  localparam int HVW    = 10;

  localparam logic [CW_DEF-1:0] WHITE = 12'hFFF;
  localparam logic [CW_DEF-1:0] BLACK = 12'h000;
  localparam logic [CW_DEF-1:0] GREEN = 12'h0F0;
  localparam logic [CW_DEF-1:0] BLUE  = 12'h00F;

  typedef struct packed {
    logic hs;
    logic vs;
    logic br;
  } sync_t;

  // Syncs are active-low, so the idle bundle keeps them high and blanks.
  localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, br: 1'b0};

  // One extra bit keeps org+size from wrapping back onto small positions.
  function automatic logic in_box(input logic [HVW-1:0] pos,
                                  input logic [HVW-1:0] org,
                                  input int unsigned    size);
    logic [HVW:0] p;
    logic [HVW:0] lo;
    logic [HVW:0] hi;
    p  = {1'b0, pos};
    lo = {1'b0, org};
    hi = lo + size[HVW:0];
    return (p >= lo) && (p < hi);
  endfunction

endpackage

// File: rtl/vga_layer_compositor_if.sv
// Raw timing from the display controller in, aligned pins out to the connector.
interface vga_layer_compositor_if #(
  parameter int CW = 12
);
  logic                          pix_en;
  logic [fpsr_vga_pkg::HVW-1:0]  hc;
  logic [fpsr_vga_pkg::HVW-1:0]  vc;
  logic                          hSync_in;
  logic                          vSync_in;
  logic                          bright_in;
  logic                          hSync;
  logic                          vSync;
  logic                          bright;
  logic [CW/3-1:0]               vgaR;
  logic [CW/3-1:0]               vgaG;
  logic [CW/3-1:0]               vgaB;

  modport master (
    output pix_en, hc, vc, hSync_in, vSync_in, bright_in,
    input  hSync, vSync, bright, vgaR, vgaG, vgaB
  );

  modport slave (
    input  pix_en, hc, vc, hSync_in, vSync_in, bright_in,
    output hSync, vSync, bright, vgaR, vgaG, vgaB
  );
endinterface

// File: rtl/vga_layer_prio_enc.sv
// Highest-set-bit select of a colour and its index; index N and dflt_rgb
// are returned when nothing is selected.
module vga_layer_prio_enc #(
  parameter int N  = 12,
  parameter int CW = 12,
  parameter int IW = $clog2(N + 1)
) (
  input  logic [N-1:0]    sel,
  input  logic [N*CW-1:0] rgb_vec,
  input  logic [CW-1:0]   dflt_rgb,
  output logic [CW-1:0]   sel_rgb,
  output logic [IW-1:0]   sel_idx
);

  always_comb begin
    sel_rgb = dflt_rgb;
    sel_idx = IW'(N);
    for (int i = 0; i < N; i++) begin
      if (sel[i]) begin
        sel_rgb = rgb_vec[i*CW +: CW];
        sel_idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/vga_layer_compositor.sv
// Priority compositor of sprite layers over a background with blinking
// indicator squares on top; two pix_en-qualified stages to the VGA pins.
module vga_layer_compositor
  import fpsr_vga_pkg::*;
#(
  parameter int N_LAYERS   = 12,
  parameter int CW         = 12,
  parameter int N_IND      = 2,
  parameter int IND_SIZE   = 20,
  parameter int BLINK_LOG2 = 5,
  parameter int TLW        = $clog2(N_LAYERS + 1)
) (
  input  logic                    ClkPort,
  input  logic                    Reset,
  vga_layer_compositor_if.slave   vga,
  input  logic [CW-1:0]           bg_rgb,
  input  logic [N_LAYERS*CW-1:0]  layer_rgb,
  input  logic [N_LAYERS-1:0]     layer_en_req,
  input  logic [N_IND-1:0]        ind_on,
  input  logic [N_IND-1:0]        ind_blink,
  input  logic [N_IND*HVW-1:0]    ind_x,
  input  logic [N_IND*HVW-1:0]    ind_y,
  input  logic [N_IND*CW-1:0]     ind_rgb,
  output logic [TLW-1:0]          top_layer,
  output logic                    frame_start
);

  localparam int CC  = CW / 3;
  localparam int IIW = $clog2(N_IND + 1);

  function automatic logic [CW-1:0] blank_rgb(input logic [CW-1:0] rgb,
                                               input logic          br);
    return br ? rgb : '0;
  endfunction

  logic                  frame_go;
  logic [N_LAYERS-1:0]   en_shadow;
  logic [N_LAYERS-1:0]   en_eff;
  logic [BLINK_LOG2-1:0] frame_cnt;
  logic [N_LAYERS-1:0]   opaque;
  logic [CW-1:0]         win_rgb;
  logic [TLW-1:0]        win_idx;
  logic [N_IND-1:0]      ind_hit;

  assign frame_go = vga.pix_en && (vga.hc == '0) && (vga.vc == '0);

  always_ff @(posedge ClkPort) begin
    if (!Reset) begin
      en_shadow   <= '1;
      frame_cnt   <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_go;
      if (frame_go) begin
        en_shadow <= layer_en_req;
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // Pixel (0,0) already belongs to the new frame, so it sees the new enables.
  assign en_eff = frame_go ? layer_en_req : en_shadow;

  always_comb begin
    opaque = '0;
    for (int i = 0; i < N_LAYERS; i++) begin
      opaque[i] = en_eff[i] && (layer_rgb[i*CW +: CW] != bg_rgb);
    end
  end

  vga_layer_prio_enc #(
    .N  (N_LAYERS),
    .CW (CW),
    .IW (TLW)
  ) u_layer_enc (
    .sel      (opaque),
    .rgb_vec  (layer_rgb),
    .dflt_rgb (bg_rgb),
    .sel_rgb  (win_rgb),
    .sel_idx  (win_idx)
  );

  always_comb begin
    ind_hit = '0;
    for (int k = 0; k < N_IND; k++) begin
      ind_hit[k] = ind_on[k]
                && in_box(vga.hc, ind_x[k*HVW +: HVW], IND_SIZE)
                && in_box(vga.vc, ind_y[k*HVW +: HVW], IND_SIZE)
                && (!ind_blink[k] || frame_cnt[BLINK_LOG2-1]);
    end
  end

  // ---- stage 1: layer winner, indicator hits, raw syncs ----
  logic [CW-1:0]    col_p1;
  logic [TLW-1:0]   idx_p1;
  logic [N_IND-1:0] hit_p1;
  sync_t            sync_p1;

  always_ff @(posedge ClkPort) begin
    if (!Reset) begin
      col_p1  <= '0;
      idx_p1  <= TLW'(N_LAYERS);
      hit_p1  <= '0;
      sync_p1 <= SYNC_IDLE;
    end else if (vga.pix_en) begin
      col_p1  <= win_rgb;
      idx_p1  <= win_idx;
      hit_p1  <= ind_hit;
      sync_p1 <= '{hs: vga.hSync_in, vs: vga.vSync_in, br: vga.bright_in};
    end
  end

  logic [CW-1:0]  ind_sel_rgb;
  logic [IIW-1:0] ind_idx;
  logic [CW-1:0]  mix_rgb;

  vga_layer_prio_enc #(
    .N  (N_IND),
    .CW (CW),
    .IW (IIW)
  ) u_ind_enc (
    .sel      (hit_p1),
    .rgb_vec  (ind_rgb),
    .dflt_rgb ('0),
    .sel_rgb  (ind_sel_rgb),
    .sel_idx  (ind_idx)
  );

  assign mix_rgb = (ind_idx != IIW'(N_IND)) ? ind_sel_rgb : col_p1;

  // ---- stage 2: indicator override and blanking to the pins ----
  logic [CW-1:0]  rgb_p2;
  logic [TLW-1:0] idx_p2;
  sync_t          sync_p2;

  always_ff @(posedge ClkPort) begin
    if (!Reset) begin
      rgb_p2  <= '0;
      idx_p2  <= TLW'(N_LAYERS);
      sync_p2 <= SYNC_IDLE;
    end else if (vga.pix_en) begin
      rgb_p2  <= blank_rgb(mix_rgb, sync_p1.br);
      idx_p2  <= idx_p1;
      sync_p2 <= sync_p1;
    end
  end

  assign vga.vgaR   = rgb_p2[CW-1 -: CC];
  assign vga.vgaG   = rgb_p2[2*CC-1 -: CC];
  assign vga.vgaB   = rgb_p2[CC-1:0];
  assign vga.hSync  = sync_p2.hs;
  assign vga.vSync  = sync_p2.vs;
  assign vga.bright = sync_p2.br;
  assign top_layer  = idx_p2;

endmodule
